uart_cmd_assembler: RTL



---
 rtl/uart_cmd_assembler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - frames three UART bytes into one 24-bit command
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   rdy, rx_data  byte-valid level and byte from the UART receiver
//   clr_rdy       one-cycle acknowledge of each accepted byte
//   cmd, cmd_rdy  assembled command {opcode, data_hi, data_lo} and its valid level
//   clr_cmd_rdy   consumer acknowledge, clears cmd_rdy
//   clr_err       clears both sticky error flags
//   timeout_err   a partial command was discarded after TIMEOUT idle cycles
//   overrun_err   a command completed while the previous one was unconsumed
module uart_cmd_assembler #(
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        clr_err,
    output logic        timeout_err,
    output logic        overrun_err
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } state_t;

    state_t      state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]  byte0, byte0_n;
    logic [7:0]  byte1, byte1_n;
    logic [23:0] cmd_n;
    logic        cmd_rdy_n;
    logic        timeout_err_n;
    logic        overrun_err_n;
    logic        accept;
    logic        expire;
    logic        complete;
    logic        timeout_set;
    logic        overrun_set;

    // clr_rdy is high in the cycle after an accept, while the receiver's rdy
    // may still be high for the byte just taken; masking avoids taking it twice.
    assign accept = rdy & ~clr_rdy;

    // An accept in the expiry cycle takes priority over the timeout.
    assign expire = (state != WAIT_B0) && !accept && (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_B0;
            cnt         <= '0;
            byte0       <= 8'h00;
            byte1       <= 8'h00;
            clr_rdy     <= 1'b0;
            cmd         <= 24'h0;
            cmd_rdy     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            byte0       <= byte0_n;
            byte1       <= byte1_n;
            clr_rdy     <= accept;
            cmd         <= cmd_n;
            cmd_rdy     <= cmd_rdy_n;
            timeout_err <= timeout_err_n;
            overrun_err <= overrun_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        byte0_n     = byte0;
        byte1_n     = byte1;
        cmd_n       = cmd;
        complete    = 1'b0;
        timeout_set = 1'b0;
        overrun_set = 1'b0;

        case (state)
            WAIT_B0: begin
                cnt_n = '0;
                if (accept) begin
                    byte0_n = rx_data;
                    state_n = WAIT_B1;
                end
            end
            WAIT_B1: begin
                if (accept) begin
                    byte1_n = rx_data;
                    cnt_n   = '0;
                    state_n = WAIT_B2;
                end else if (expire) begin
                    byte0_n     = 8'h00;
                    cnt_n       = '0;
                    timeout_set = 1'b1;
                    state_n     = WAIT_B0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_B2: begin
                if (accept) begin
                    cnt_n   = '0;
                    state_n = WAIT_B0;
                    // A same-cycle consumer acknowledge frees the output slot.
                    if (!cmd_rdy || clr_cmd_rdy) begin
                        cmd_n    = {byte0, byte1, rx_data};
                        complete = 1'b1;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end else if (expire) begin
                    byte0_n     = 8'h00;
                    byte1_n     = 8'h00;
                    cnt_n       = '0;
                    timeout_set = 1'b1;
                    state_n     = WAIT_B0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = WAIT_B0;
            end
        endcase

        // Set events win over clears in the same cycle.
        cmd_rdy_n     = complete ? 1'b1 : (clr_cmd_rdy ? 1'b0 : cmd_rdy);
        timeout_err_n = timeout_set | (timeout_err & ~clr_err);
        overrun_err_n = overrun_set | (overrun_err & ~clr_err);
    end

endmodule
